// File: rtl/isq_lin.sv
// -----------------------------------------------------------------------------
// isq_lin : one line (slot) of the instruction issue queue.
//
// Holds an INST_WIDTH-bit instruction plus two status flags, packed as
//   {val, wat, inst}  (val = MSB, wat = MSB-1, inst = low INST_WIDTH bits).
// The issue-queue controller loads the line, sets/clears the flags and
// flushes the line. The registered contents drive isq_lin_out directly.
//
// Ports
//   clk          in   rising-edge clock
//   rst_n        in   asynchronous reset, ACTIVE-HIGH (legacy name kept)
//   en           in   load isq_lin_in into the whole line
//   clr_wat      in   clear wait flag
//   set_wat      in   set wait flag
//   clr_val      in   clear valid flag
//   set_val      in   set valid flag
//   fls          in   flush: zero the whole line
//   isq_lin_in   in   [ISQ_LINE_WIDTH-1:0] new line contents {val, wat, inst}
//   isq_lin_out  out  [ISQ_LINE_WIDTH-1:0] registered line contents
//
// Per-edge priority: fls > en > flag ops > hold. Within the flag ops each
// flag updates independently and a clear beats a simultaneous set.
// -----------------------------------------------------------------------------
module isq_lin #(
    parameter  int INST_WIDTH     = 14,
    // Derived from INST_WIDTH so the two can never disagree.
    localparam int ISQ_LINE_WIDTH = INST_WIDTH + 2
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      en,
    input  logic                      clr_wat,
    input  logic                      set_wat,
    input  logic                      clr_val,
    input  logic                      set_val,
    input  logic                      fls,
    input  logic [ISQ_LINE_WIDTH-1:0] isq_lin_in,
    output logic [ISQ_LINE_WIDTH-1:0] isq_lin_out
);

    localparam int VAL_BIT = ISQ_LINE_WIDTH - 1;
    localparam int WAT_BIT = ISQ_LINE_WIDTH - 2;

    logic [ISQ_LINE_WIDTH-1:0] r_line;
    logic [ISQ_LINE_WIDTH-1:0] w_line_nxt;
    logic                      w_val_nxt;
    logic                      w_wat_nxt;

    // Flag updates; clear dominates set, otherwise hold.
    always_comb begin
        w_val_nxt = r_line[VAL_BIT];
        if (clr_val) begin
            w_val_nxt = 1'b0;
        end else if (set_val) begin
            w_val_nxt = 1'b1;
        end

        w_wat_nxt = r_line[WAT_BIT];
        if (clr_wat) begin
            w_wat_nxt = 1'b0;
        end else if (set_wat) begin
            w_wat_nxt = 1'b1;
        end
    end

    // Line next-state: flush beats load, load beats flag ops. Flag ops
    // only ever touch the two flag bits, so inst is held.
    always_comb begin
        w_line_nxt = r_line;
        if (fls) begin
            w_line_nxt = '0;
        end else if (en) begin
            w_line_nxt = isq_lin_in;
        end else begin
            w_line_nxt[VAL_BIT] = w_val_nxt;
            w_line_nxt[WAT_BIT] = w_wat_nxt;
        end
    end

    // rst_n is active-high despite its name.
    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            r_line <= '0;
        end else begin
            r_line <= w_line_nxt;
        end
    end

    assign isq_lin_out = r_line;

endmodule

// File: tb/tb_isq_lin.sv
// -----------------------------------------------------------------------------
// Testbench for isq_lin (INST_WIDTH = 14, 16-bit line).
// Stimulus drives controls just after a rising edge and queues the value the
// line must hold after the next edge; an independent monitor pops and
// compares on each falling edge.
// -----------------------------------------------------------------------------
module tb_isq_lin;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        en;
    logic        clr_wat;
    logic        set_wat;
    logic        clr_val;
    logic        set_val;
    logic        fls;
    logic [15:0] din;
    logic [15:0] dout;

    logic [15:0] exp_q[$];
    int          id_q[$];
    int          n_cmp     = 0;
    int          n_bad     = 0;
    int          step_id   = 0;
    bit          stim_done = 1'b0;

    always #5 clk = ~clk;

    isq_lin #(
        .INST_WIDTH(14)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .en         (en),
        .clr_wat    (clr_wat),
        .set_wat    (set_wat),
        .clr_val    (clr_val),
        .set_val    (set_val),
        .fls        (fls),
        .isq_lin_in (din),
        .isq_lin_out(dout)
    );

    task automatic ctl(input logic f, input logic e, input logic cv,
                       input logic sv, input logic cw, input logic sw,
                       input logic [15:0] d);
        fls     = f;
        en      = e;
        clr_val = cv;
        set_val = sv;
        clr_wat = cw;
        set_wat = sw;
        din     = d;
    endtask

    task automatic idle();
        ctl(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000);
    endtask

    // Queue an expectation for the current (already settled) line value.
    task automatic push_now(input logic [15:0] x);
        exp_q.push_back(x);
        id_q.push_back(step_id);
        step_id++;
    endtask

    // Let one rising edge consume the driven controls, then queue the result.
    task automatic expect_next(input logic [15:0] x);
        @(posedge clk);
        #1;
        push_now(x);
    endtask

    // Stimulus
    initial begin
        rst_n = 1'b1;
        idle();
        expect_next(16'h0000);                      // reset state
        rst_n = 1'b0;

        // Load then clear flags
        ctl(0, 1, 0, 0, 0, 0, 16'hFBAB); expect_next(16'hFBAB);
        ctl(0, 0, 1, 0, 0, 0, 16'h0000); expect_next(16'h7BAB);
        ctl(0, 0, 0, 0, 1, 0, 16'h0000); expect_next(16'h3BAB);

        // Flush then set flags
        ctl(1, 0, 0, 0, 0, 0, 16'h0000); expect_next(16'h0000);
        ctl(0, 0, 0, 1, 0, 0, 16'h0000); expect_next(16'h8000);
        ctl(0, 0, 0, 0, 0, 1, 16'h0000);
        repeat (40) expect_next(16'hC000);

        // Priority and conflicts
        ctl(1, 1, 0, 0, 0, 0, 16'hFFFF); expect_next(16'h0000);
        ctl(0, 1, 1, 0, 0, 0, 16'hC123); expect_next(16'hC123);
        ctl(0, 1, 0, 0, 0, 0, 16'h8001); expect_next(16'h8001);
        ctl(0, 0, 1, 1, 0, 0, 16'h0000); expect_next(16'h0001);
        ctl(0, 1, 0, 0, 1, 1, 16'h7FFF); expect_next(16'h7FFF);

        // Hold
        ctl(0, 1, 0, 0, 0, 0, 16'h4ABC); expect_next(16'h4ABC);
        idle();
        repeat (10) expect_next(16'h4ABC);

        // Independent flags, wat clear-over-set, wat-only line
        ctl(0, 1, 0, 0, 0, 0, 16'h8005); expect_next(16'h8005);
        ctl(0, 0, 1, 0, 0, 1, 16'h0000); expect_next(16'h4005);
        ctl(0, 0, 0, 0, 1, 1, 16'h0000); expect_next(16'h0005);
        ctl(1, 0, 0, 0, 0, 0, 16'h0000); expect_next(16'h0000);
        ctl(0, 0, 0, 0, 0, 1, 16'h0000); expect_next(16'h4000);

        // Asynchronous reset mid-cycle, held across an edge with en asserted
        ctl(0, 1, 0, 0, 0, 0, 16'hFBAB); expect_next(16'hFBAB);
        idle();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        push_now(16'h0000);                          // before any further edge
        ctl(0, 1, 0, 0, 0, 0, 16'hFFFF); expect_next(16'h0000);
        rst_n = 1'b0;
        idle();                          expect_next(16'h0000);
        ctl(0, 1, 0, 0, 0, 0, 16'h1234); expect_next(16'h1234);
        idle();

        stim_done = 1'b1;
    end

    // Monitor / scoreboard
    initial begin
        logic [15:0] e;
        int          id;
        int          drain;
        drain = 0;
        while (!(stim_done && exp_q.size() == 0) && drain < 20) begin
            @(negedge clk);
            if (exp_q.size() != 0) begin
                e  = exp_q.pop_front();
                id = id_q.pop_front();
                n_cmp++;
                if (dout !== e) begin
                    n_bad++;
                    $display("FAIL step%0d isq_lin_out: got 0x%h, required 0x%h",
                             id, dout, e);
                end
            end
            if (stim_done) drain++;
        end
        if (exp_q.size() != 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL drain: %0d expectations left unchecked, required 0",
                     exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
